// File: rtl/mwave_pkg.sv
// Shared types and constants for the microwave controller: state codes, 7-seg letters, status words.
// Segment order within a letter is {g,f,e,d,c,b,a}, active-high.
package mwave_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        READY  = 3'd1,
        COOK   = 3'd2,
        PAUSE  = 3'd3,
        RESUME = 3'd4,
        DONE   = 3'd5
    } state_t;

    localparam logic [6:0] SEG_O = 7'h3F;
    localparam logic [6:0] SEG_P = 7'h73;
    localparam logic [6:0] SEG_E = 7'h79;
    localparam logic [6:0] SEG_N = 7'h37;
    localparam logic [6:0] SEG_R = 7'h50;
    localparam logic [6:0] SEG_G = 7'h3D;
    localparam logic [6:0] SEG_C = 7'h39;
    localparam logic [6:0] SEG_K = 7'h75;
    localparam logic [6:0] SEG_S = 7'h6D;
    localparam logic [6:0] SEG_T = 7'h78;
    localparam logic [6:0] SEG_H = 7'h76;
    localparam logic [6:0] SEG_L = 7'h38;
    localparam logic [6:0] SEG_D = 7'h5E;

    // char0 occupies the top seven bits
    localparam logic [27:0] WORD_OPEN = {SEG_O, SEG_P, SEG_E, SEG_N};
    localparam logic [27:0] WORD_PROG = {SEG_P, SEG_R, SEG_O, SEG_G};
    localparam logic [27:0] WORD_COOK = {SEG_C, SEG_O, SEG_O, SEG_K};
    localparam logic [27:0] WORD_STOP = {SEG_S, SEG_T, SEG_O, SEG_P};
    localparam logic [27:0] WORD_HOLD = {SEG_H, SEG_O, SEG_L, SEG_D};
    localparam logic [27:0] WORD_DONE = {SEG_D, SEG_O, SEG_N, SEG_E};

    function automatic logic [27:0] state_word(state_t s);
        case (s)
            IDLE:    return WORD_OPEN;
            READY:   return WORD_PROG;
            COOK:    return WORD_COOK;
            PAUSE:   return WORD_STOP;
            RESUME:  return WORD_HOLD;
            DONE:    return WORD_DONE;
            default: return WORD_OPEN;
        endcase
    endfunction

endpackage

// File: rtl/mwave_tick_gen.sv
// One-second tick prescaler: counts 0..TICKS_PER_SEC-1 while run, pulses tick on the last count.
module mwave_tick_gen #(
    parameter int TICKS_PER_SEC = 100
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic clear,
    output logic tick
);
    localparam int CNT_W = $clog2(TICKS_PER_SEC);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICKS_PER_SEC - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (run) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

    assign tick = run && (cnt == LAST);

endmodule

// File: rtl/microwave_ctrl_gen2.sv
// Microwave controller: door/button FSM, seconds countdown, tick-based power duty cycling, status display.
// Build option MWAVE_CHIME_EN adds a toggling chime after cook completion; otherwise chime is tied low.
//
// state  | meaning
// IDLE   | door open, nothing programmed
// READY  | door closed, programming
// COOK   | heating, counting down
// PAUSE  | door opened mid-cook, time held
// RESUME | door closed after pause, waiting for start
// DONE   | countdown expired
module microwave_ctrl_gen2
    import mwave_pkg::*;
#(
    parameter int TIMER_W       = 7,
    parameter int MAX_TIME      = 99,
    parameter int TICKS_PER_SEC = 100,
    parameter int POWER_LEVELS  = 4,
    parameter int CHIME_TICKS   = 6,
    localparam int PWR_W        = (POWER_LEVELS > 1) ? $clog2(POWER_LEVELS) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [PWR_W-1:0]   power_level,
    input  logic [TIMER_W-1:0] timer_in,
    input  logic               door_closed,
    input  logic               start_btn,
    input  logic               cancel_btn,
    output logic [2:0]         state,
    output logic [TIMER_W-1:0] time_left,
    output logic               heater_on,
    output logic               done_pulse,
    output logic               chime,
    output logic [27:0]        state_disp
);
    localparam logic [PWR_W-1:0] TOP_LEVEL = PWR_W'(POWER_LEVELS - 1);

    state_t             state_q, nxt_state;
    logic [TIMER_W-1:0] nxt_time, load_time;
    logic [PWR_W-1:0]   level_q, nxt_level, level_req;
    logic [PWR_W-1:0]   duty_q, nxt_duty;
    logic               nxt_done;
    logic               start_prev, cancel_prev;
    logic               start_rise, cancel_rise;
    logic               tick, run;

    assign start_rise  = start_btn & ~start_prev;
    assign cancel_rise = cancel_btn & ~cancel_prev;
    assign level_req   = (32'(power_level) >= POWER_LEVELS) ? TOP_LEVEL : power_level;
    assign load_time   = (32'(timer_in) > MAX_TIME) ? TIMER_W'(MAX_TIME) : timer_in;

    mwave_tick_gen #(.TICKS_PER_SEC(TICKS_PER_SEC)) u_tick (
        .clk   (clk),
        .reset (reset),
        .run   (run),
        .clear (!run),
        .tick  (tick)
    );

    always_comb begin
        nxt_state = state_q;
        nxt_time  = time_left;
        nxt_level = level_q;
        nxt_duty  = duty_q;
        nxt_done  = 1'b0;
        if (cancel_rise && state_q != IDLE) begin
            nxt_time  = '0;
            nxt_state = door_closed ? READY : IDLE;
        end else begin
            case (state_q)
                IDLE: if (door_closed) nxt_state = READY;
                READY: begin
                    if (!door_closed) begin
                        nxt_state = IDLE;
                    end else if (start_rise && timer_in != '0) begin
                        nxt_state = COOK;
                        nxt_time  = load_time;
                        nxt_level = level_req;
                        nxt_duty  = '0;
                    end
                end
                COOK: begin
                    // door-open outranks an expiring tick, so the last second is kept
                    if (!door_closed) begin
                        nxt_state = PAUSE;
                    end else if (tick) begin
                        nxt_duty = (duty_q == TOP_LEVEL) ? '0 : duty_q + 1'b1;
                        if (time_left == TIMER_W'(1)) begin
                            nxt_state = DONE;
                            nxt_time  = '0;
                            nxt_done  = 1'b1;
                        end else begin
                            nxt_time = time_left - 1'b1;
                        end
                    end
                end
                PAUSE: if (door_closed) nxt_state = RESUME;
                RESUME: begin
                    if (!door_closed) begin
                        nxt_state = PAUSE;
                    end else if (start_rise) begin
                        nxt_state = COOK;
                        nxt_level = level_req;
                        nxt_duty  = '0;
                    end
                end
                DONE: if (!door_closed) nxt_state = IDLE;
                default: nxt_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            time_left   <= '0;
            level_q     <= '0;
            duty_q      <= '0;
            heater_on   <= 1'b0;
            done_pulse  <= 1'b0;
            state_disp  <= WORD_OPEN;
            start_prev  <= 1'b0;
            cancel_prev <= 1'b0;
        end else begin
            state_q     <= nxt_state;
            time_left   <= nxt_time;
            level_q     <= nxt_level;
            duty_q      <= nxt_duty;
            heater_on   <= (nxt_state == COOK) && (nxt_duty <= nxt_level);
            done_pulse  <= nxt_done;
            state_disp  <= state_word(nxt_state);
            start_prev  <= start_btn;
            cancel_prev <= cancel_btn;
        end
    end

    assign state = state_q;

`ifdef MWAVE_CHIME_EN
    localparam int CHIME_W = $clog2(CHIME_TICKS + 1);

    logic [CHIME_W-1:0] chime_cnt;

    // prescaler keeps running in DONE only while the chime still has ticks left
    assign run = (state_q == COOK) || (state_q == DONE && chime_cnt != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            chime     <= 1'b0;
            chime_cnt <= '0;
        end else if (nxt_done) begin
            chime     <= 1'b1;
            chime_cnt <= CHIME_W'(CHIME_TICKS);
        end else if (nxt_state != DONE) begin
            chime     <= 1'b0;
            chime_cnt <= '0;
        end else if (tick && chime_cnt != '0) begin
            chime_cnt <= chime_cnt - 1'b1;
            chime     <= (chime_cnt == CHIME_W'(1)) ? 1'b0 : ~chime;
        end
    end
`else
    assign run   = (state_q == COOK);
    assign chime = 1'b0;
`endif

endmodule

// File: tb/tb_microwave_ctrl_gen2.sv
// Directed bench for microwave_ctrl_gen2 with a 4-clock second and four power levels.
module tb_microwave_ctrl_gen2;

    localparam logic [2:0] S_IDLE = 3'd0, S_READY = 3'd1, S_COOK = 3'd2,
                           S_PAUSE = 3'd3, S_RESUME = 3'd4, S_DONE = 3'd5;

    localparam logic [6:0] L_O = 7'h3F, L_P = 7'h73, L_E = 7'h79, L_N = 7'h37,
                           L_R = 7'h50, L_G = 7'h3D, L_C = 7'h39, L_K = 7'h75,
                           L_S = 7'h6D, L_T = 7'h78, L_H = 7'h76, L_L = 7'h38, L_D = 7'h5E;

    localparam logic [27:0] W_OPEN = {L_O, L_P, L_E, L_N};
    localparam logic [27:0] W_COOK = {L_C, L_O, L_O, L_K};
    localparam logic [27:0] W_STOP = {L_S, L_T, L_O, L_P};
    localparam logic [27:0] W_HOLD = {L_H, L_O, L_L, L_D};
    localparam logic [27:0] W_DONE = {L_D, L_O, L_N, L_E};
    localparam logic [27:0] W_PROG = {L_P, L_R, L_O, L_G};

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  power_level;
    logic [6:0]  timer_in;
    logic        door_closed, start_btn, cancel_btn;
    logic [2:0]  state;
    logic [6:0]  time_left;
    logic        heater_on, done_pulse, chime;
    logic [27:0] state_disp;

    int checks = 0;
    int errors = 0;

    microwave_ctrl_gen2 #(
        .TIMER_W(7), .MAX_TIME(99), .TICKS_PER_SEC(4), .POWER_LEVELS(4), .CHIME_TICKS(6)
    ) dut (
        .clk(clk), .reset(reset), .power_level(power_level), .timer_in(timer_in),
        .door_closed(door_closed), .start_btn(start_btn), .cancel_btn(cancel_btn),
        .state(state), .time_left(time_left), .heater_on(heater_on),
        .done_pulse(done_pulse), .chime(chime), .state_disp(state_disp)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // advance n clocks, leave the bench 1 ns past the last edge
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; power_level = '0; timer_in = '0;
        door_closed = 1'b0; start_btn = 1'b0; cancel_btn = 1'b0;
        step(2);
        check_eq("rst_state", state, S_IDLE);
        check_eq("rst_time", time_left, 0);
        check_eq("rst_heater", heater_on, 0);
        check_eq("rst_done", done_pulse, 0);
        check_eq("rst_chime", chime, 0);
        check_eq("rst_disp", state_disp, W_OPEN);
        reset = 1'b0;

        // full cook at top level
        door_closed = 1'b1; step(1);
        check_eq("t1_ready", state, S_READY);
        check_eq("t1_disp_prog", state_disp, W_PROG);
        timer_in = 7'd3; power_level = 2'd3; start_btn = 1'b1; step(1);
        start_btn = 1'b0;
        check_eq("t1_cook", state, S_COOK);
        check_eq("t1_t3", time_left, 3);
        check_eq("t1_heat0", heater_on, 1);
        step(3);
        check_eq("t1_t3_hold", time_left, 3);
        step(1);
        check_eq("t1_t2", time_left, 2);
        check_eq("t1_heat1", heater_on, 1);
        step(4);
        check_eq("t1_t1", time_left, 1);
        check_eq("t1_heat2", heater_on, 1);
        step(4);
        check_eq("t1_done", state, S_DONE);
        check_eq("t1_t0", time_left, 0);
        check_eq("t1_pulse", done_pulse, 1);
        check_eq("t1_heat_off", heater_on, 0);
        check_eq("t1_disp_done", state_disp, W_DONE);
`ifndef MWAVE_CHIME_EN
        check_eq("t1_chime_off", chime, 0);
`endif
        step(1);
        check_eq("t1_pulse_end", done_pulse, 0);
        start_btn = 1'b1; step(1);
        check_eq("t1_done_start", state, S_DONE);
        start_btn = 1'b0;

        // level 1 duty pattern: on,on,off,off
        door_closed = 1'b0; step(1);
        check_eq("t2_idle", state, S_IDLE);
        door_closed = 1'b1; step(1);
        timer_in = 7'd5; power_level = 2'd1; start_btn = 1'b1; step(1);
        start_btn = 1'b0;
        check_eq("t2_disp", state_disp, W_COOK);
        check_eq("t2_h0", heater_on, 1);
        step(4); check_eq("t2_h1", heater_on, 1); check_eq("t2_t4", time_left, 4);
        step(4); check_eq("t2_h2", heater_on, 0);
        step(4); check_eq("t2_h3", heater_on, 0);
        step(4); check_eq("t2_h4", heater_on, 1); check_eq("t2_t1", time_left, 1);
        cancel_btn = 1'b1; step(1);
        check_eq("t2_cancel", state, S_READY);
        check_eq("t2_cancel_t", time_left, 0);
        cancel_btn = 1'b0; step(1);

        // pause / resume, then door-open racing expiry
        timer_in = 7'd6; power_level = 2'd3; start_btn = 1'b1; step(1);
        start_btn = 1'b0;
        step(8);
        check_eq("t3_t4", time_left, 4);
        door_closed = 1'b0; step(1);
        check_eq("t3_pause", state, S_PAUSE);
        check_eq("t3_stop", state_disp, W_STOP);
        check_eq("t3_heat", heater_on, 0);
        step(10);
        check_eq("t3_held", time_left, 4);
        door_closed = 1'b1; step(1);
        check_eq("t3_resume", state, S_RESUME);
        check_eq("t3_hold", state_disp, W_HOLD);
        start_btn = 1'b1; step(1);
        start_btn = 1'b0;
        check_eq("t3_recook", state, S_COOK);
        check_eq("t3_rt4", time_left, 4);
        step(4); check_eq("t3_rt3", time_left, 3);
        step(8); check_eq("t3_rt1", time_left, 1);
        step(3);
        door_closed = 1'b0; step(1);
        check_eq("t3_race_st", state, S_PAUSE);
        check_eq("t3_race_t", time_left, 1);
        check_eq("t3_race_pulse", done_pulse, 0);
        cancel_btn = 1'b1; step(1);
        check_eq("t3_cancel_idle", state, S_IDLE);
        check_eq("t3_cancel_t", time_left, 0);
        cancel_btn = 1'b0;

        // saturation and zero-time start
        door_closed = 1'b1; step(1);
        timer_in = 7'd120; power_level = 2'd2; start_btn = 1'b1; step(1);
        start_btn = 1'b0;
        check_eq("t4_sat", time_left, 99);
        cancel_btn = 1'b1; step(1);
        check_eq("t4_cancel", state, S_READY);
        cancel_btn = 1'b0; timer_in = 7'd0; step(1);
        start_btn = 1'b1; step(1);
        check_eq("t4_zero_start", state, S_READY);
        check_eq("t4_zero_time", time_left, 0);
        start_btn = 1'b0; step(1);

        // cancel + start same cycle, held start, reset mid-cook
        timer_in = 7'd3; start_btn = 1'b1; step(1);
        check_eq("t5_cook", state, S_COOK);
        start_btn = 1'b0; step(1);
        cancel_btn = 1'b1; start_btn = 1'b1; step(1);
        check_eq("t5_cs_state", state, S_READY);
        check_eq("t5_cs_time", time_left, 0);
        check_eq("t5_cs_heat", heater_on, 0);
        step(2);
        check_eq("t5_no_retrig", state, S_READY);
        cancel_btn = 1'b0; start_btn = 1'b0; step(1);
        start_btn = 1'b1; step(1);
        check_eq("t5_cook2", state, S_COOK);
        reset = 1'b1; step(1);
        check_eq("t5_rst_state", state, S_IDLE);
        check_eq("t5_rst_time", time_left, 0);
        check_eq("t5_rst_heat", heater_on, 0);
        check_eq("t5_rst_disp", state_disp, W_OPEN);
        check_eq("t5_rst_chime", chime, 0);
        reset = 1'b0;

`ifdef MWAVE_CHIME_EN
        step(1);
        start_btn = 1'b0; timer_in = 7'd1; power_level = 2'd0; step(1);
        check_eq("t6_ready", state, S_READY);
        start_btn = 1'b1; step(1);
        start_btn = 1'b0;
        step(4);
        check_eq("t6_done", state, S_DONE);
        check_eq("t6_c0", chime, 1);
        step(4); check_eq("t6_c1", chime, 0);
        step(4); check_eq("t6_c2", chime, 1);
        step(4); check_eq("t6_c3", chime, 0);
        step(4); check_eq("t6_c4", chime, 1);
        step(4); check_eq("t6_c5", chime, 0);
        step(4); check_eq("t6_c6", chime, 0);
        step(8); check_eq("t6_quiet", chime, 0);
        door_closed = 1'b0; step(1);
        door_closed = 1'b1; step(1);
        start_btn = 1'b1; step(1);
        start_btn = 1'b0;
        step(4); check_eq("t6b_c0", chime, 1);
        step(4); check_eq("t6b_c1", chime, 0);
        step(4); check_eq("t6b_c2", chime, 1);
        door_closed = 1'b0; step(1);
        check_eq("t6b_idle", state, S_IDLE);
        check_eq("t6b_cleared", chime, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
